clkgate_ctrl: RTL

CLKGATE_CTRL -- requirements
Module: clkgate_ctrl

---
 rtl/clkgate_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/clkgate_ctrl.sv
// Per-channel idle-driven clock gating controller with hysteresis and timed wake-up.
// Each channel owns a RUN/COUNT/OFF/WAKE FSM driving a latch-based glitch-free clock gate.
module clkgate_ctrl #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 8,
    parameter int WAKE_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              te,
    input  logic [CNT_W-1:0]  cfg_idle_thresh,
    input  logic [NUM_CH-1:0] cfg_force_on,
    input  logic [NUM_CH-1:0] ch_busy,
    input  logic [NUM_CH-1:0] ch_wake_req,
    output logic [NUM_CH-1:0] ch_wake_ack,
    output logic [NUM_CH-1:0] ch_gated,
    output logic              all_gated,
    output logic [NUM_CH-1:0] clk_out
);

    // The counter must also hold WAKE_CYC (up to 255), so it is never narrower than 8 bits.
    localparam int CW = (CNT_W > 8) ? CNT_W : 8;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_OFF   = 2'd2;
    localparam logic [1:0] ST_WAKE  = 2'd3;

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] WAKE_LD  = CW'(WAKE_CYC);

    logic [NUM_CH-1:0] wake;
    logic [NUM_CH-1:0] en_q;
    logic [NUM_CH-1:0] en_lat;

    assign wake = ch_busy | ch_wake_req | cfg_force_on;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [1:0]    state_reg;
            logic [1:0]    state_next;
            logic [CW-1:0] cnt_reg;
            logic [CW-1:0] cnt_next;
            logic          en_reg;
            logic          ack_reg;
            logic          gated_reg;

            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                case (state_reg)
                    ST_RUN: begin
                        if (!wake[gi]) begin
                            if (cfg_idle_thresh == '0) begin
                                state_next = ST_OFF;
                                cnt_next   = '0;
                            end else begin
                                state_next = ST_COUNT;
                                cnt_next   = CW'(cfg_idle_thresh);
                            end
                        end
                    end
                    ST_COUNT: begin
                        if (wake[gi]) begin
                            state_next = ST_RUN;
                            cnt_next   = '0;
                        end else if (cnt_reg == CNT_ONE) begin
                            state_next = ST_OFF;
                            cnt_next   = '0;
                        end else begin
                            cnt_next   = cnt_reg - CNT_ONE;
                        end
                    end
                    ST_OFF: begin
                        if (wake[gi]) begin
                            state_next = ST_WAKE;
                            cnt_next   = WAKE_LD;
                        end
                    end
                    default: begin
                        // Wake sequence runs to completion even if the request drops.
                        if (cnt_reg <= CNT_ONE) begin
                            state_next = ST_RUN;
                            cnt_next   = '0;
                        end else begin
                            cnt_next   = cnt_reg - CNT_ONE;
                        end
                    end
                endcase
            end

            // Enable and status flags are registered from the next state so they line up with it.
            always_ff @(posedge clk) begin
                if (reset) begin
                    state_reg <= ST_RUN;
                    cnt_reg   <= '0;
                    en_reg    <= 1'b1;
                    ack_reg   <= 1'b1;
                    gated_reg <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                    en_reg    <= (state_next != ST_OFF);
                    ack_reg   <= (state_next == ST_RUN) || (state_next == ST_COUNT);
                    gated_reg <= (state_next == ST_OFF);
                end
            end

            // Latch is transparent only while clk is low, so the AND cannot chop a high phase.
            always_latch begin
                if (!clk) begin
                    en_lat[gi] = en_reg | te;
                end
            end

            assign en_q[gi]        = en_reg;
            assign ch_wake_ack[gi] = ack_reg;
            assign ch_gated[gi]    = gated_reg;
            assign clk_out[gi]     = clk & en_lat[gi];
        end
    endgenerate

    assign all_gated = &ch_gated;

endmodule
